// File: rtl/mmio_timer_responder.sv
// mmio_timer_responder: bus-mapped 64-bit machine timer with compare interrupt and wait-stated responses
module mmio_timer_responder #(
  parameter int                ADDR_W       = 15,
  parameter logic [ADDR_W-1:0] BASE_WADDR   = 'h4000,
  parameter int                WAIT_STATES  = 0,
  parameter logic [31:0]       PRESCALE_RST = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              read_i,
  input  logic              write_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       data_i,
  input  logic [3:0]        byte_select_i,
  output logic              mem_ready_o,
  output logic [31:0]       data_o,
  output logic              irq_o
);
  localparam logic [1:0] S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2;
  logic [1:0]  r_state;
  logic [3:0]  r_cnt;
  logic [2:0]  r_addr;
  logic [31:0] r_wdata, r_rdata, r_prescale, r_pcnt;
  logic [3:0]  r_bsel;
  logic        r_wr, r_en, r_irq_en, r_irq;
  logic [63:0] r_mtime, r_mtimecmp;
  logic        w_hit, w_load, w_wr, w_tick;
  logic [2:0]  w_rsel;
  logic [31:0] w_rval, w_mval;
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] b);
    logic [31:0] m;
    m = old;
    for (int i = 0; i < 4; i++) if (b[i]) m[8*i+:8] = d[8*i+:8];
    return m;
  endfunction
  assign w_hit  = (read_i | write_i) && addr_i[ADDR_W-1:3] == BASE_WADDR[ADDR_W-1:3];
  assign w_rsel = r_state == S_IDLE ? addr_i[2:0] : r_addr;
  assign w_load = (r_state == S_IDLE && w_hit && WAIT_STATES == 0) || (r_state == S_WAIT && r_cnt == 4'd0);
  assign w_wr   = r_state == S_RESP && r_wr && |r_bsel;
  assign w_tick = r_en && r_pcnt == r_prescale;
  // In RESP w_rval is the addressed register, so the merge yields its post-write value
  assign w_mval = merge(w_rval, r_wdata, r_bsel);
  always_comb begin
    w_rval = '0;
    case (w_rsel)
      3'd0:    w_rval = r_mtime[31:0];
      3'd1:    w_rval = r_mtime[63:32];
      3'd2:    w_rval = r_mtimecmp[31:0];
      3'd3:    w_rval = r_mtimecmp[63:32];
      3'd4:    w_rval = {30'd0, r_irq_en, r_en};
      3'd5:    w_rval = r_prescale;
      default: w_rval = '0;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_bsel  <= '0;
      r_wr    <= 1'b0;
      r_rdata <= '0;
    end else begin
      if (w_load) r_rdata <= w_rval;
      case (r_state)
        S_IDLE: if (w_hit) begin
          r_addr  <= addr_i[2:0];
          r_wdata <= data_i;
          r_bsel  <= byte_select_i;
          r_wr    <= write_i;
          r_cnt   <= 4'(WAIT_STATES - 1);
          r_state <= WAIT_STATES == 0 ? S_RESP : S_WAIT;
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd0) r_state <= S_RESP;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_mtime    <= '0;
      r_mtimecmp <= '1;
      r_en       <= 1'b0;
      r_irq_en   <= 1'b0;
      r_prescale <= PRESCALE_RST;
      r_pcnt     <= '0;
      r_irq      <= 1'b0;
    end else begin
      r_irq <= r_irq_en && r_mtime >= r_mtimecmp;
      if (w_wr && r_addr == 3'd0) r_mtime[31:0] <= w_mval;
      else if (w_wr && r_addr == 3'd1) r_mtime[63:32] <= w_mval;
      else if (w_tick) r_mtime <= r_mtime + 64'd1;
      if (w_wr && r_addr == 3'd5) r_pcnt <= '0;
      else if (r_en) r_pcnt <= w_tick ? '0 : r_pcnt + 32'd1;
      if (w_wr && r_addr == 3'd2) r_mtimecmp[31:0] <= w_mval;
      if (w_wr && r_addr == 3'd3) r_mtimecmp[63:32] <= w_mval;
      if (w_wr && r_addr == 3'd4) {r_irq_en, r_en} <= w_mval[1:0];
      if (w_wr && r_addr == 3'd5) r_prescale <= w_mval;
    end
  end
  assign mem_ready_o = r_state == S_RESP;
  assign data_o      = r_rdata;
  assign irq_o       = r_irq;
endmodule

// File: tb/tb_mmio_timer_responder.sv
// tb_mmio_timer_responder: scoreboard bench for a zero-wait and a three-wait-state timer responder
module tb_mmio_timer_responder;
  logic        clk = 1'b0, rst;
  logic        rd[2], wr[2], rdy[2], irq[2];
  logic [14:0] ad[2];
  logic [31:0] wd[2], dout[2];
  logic [3:0]  bs[2];
  logic [31:0] sb[$];
  logic [31:0] r;
  int          n_chk = 0, n_pass = 0, n;
  always #5 clk = ~clk;
  mmio_timer_responder #(.WAIT_STATES(0)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .read_i(rd[0]), .write_i(wr[0]), .addr_i(ad[0]), .data_i(wd[0]),
    .byte_select_i(bs[0]), .mem_ready_o(rdy[0]), .data_o(dout[0]), .irq_o(irq[0]));
  mmio_timer_responder #(.WAIT_STATES(3)) u_dut3 (
    .clk_i(clk), .rst_i(rst), .read_i(rd[1]), .write_i(wr[1]), .addr_i(ad[1]), .data_i(wd[1]),
    .byte_select_i(bs[1]), .mem_ready_o(rdy[1]), .data_o(dout[1]), .irq_o(irq[1]));
  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, act, exp);
  endtask
  // One bus transaction on dut d; latency is counted in negedges from the drive point
  task automatic xfer(input int d, input bit w, input logic [14:0] a, input logic [31:0] dat,
                      input logic [3:0] b, input bit chk, input logic [31:0] exp, input string tag,
                      output logic [31:0] rdat);
    int k = 0;
    logic [31:0] e;
    sb.push_back(exp);
    ad[d] = a; wd[d] = dat; bs[d] = b; rd[d] = !w; wr[d] = w;
    do begin @(negedge clk); k++; end while (!rdy[d] && k < 40);
    rd[d] = 1'b0; wr[d] = 1'b0;
    e = sb.pop_front();
    rdat = dout[d];
    check({tag, "_lat"}, 64'(k), d == 1 ? 64'd5 : 64'd2);
    if (chk) check(tag, rdat, e);
    @(posedge clk); #1;
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
  initial begin
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin rd[i] = 0; wr[i] = 0; ad[i] = 0; wd[i] = 0; bs[i] = 0; end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_ready", rdy[0], 0);
    check("rst_data", dout[0], 0);
    check("rst_irq", irq[0], 0);
    xfer(0, 0, 15'h4000, 0, 0, 1, 32'h0, "mtime_lo_rst", r);
    xfer(0, 1, 15'h4005, 3, 4'hF, 0, 0, "wr_pre", r);
    xfer(0, 1, 15'h4004, 1, 4'hF, 0, 0, "wr_en", r);
    repeat (40) @(posedge clk);
    #1 xfer(0, 0, 15'h4000, 0, 0, 0, 0, "rd_mt", r);
    check("mtime_after40", r, 10);
    xfer(0, 1, 15'h4004, 0, 4'hF, 0, 0, "dis", r);
    xfer(0, 1, 15'h4000, 32'hFFFF_FFFF, 4'hF, 0, 0, "w_lo", r);
    xfer(0, 1, 15'h4001, 0, 4'hF, 0, 0, "w_hi", r);
    xfer(0, 1, 15'h4005, 0, 4'hF, 0, 0, "w_pre0", r);
    xfer(0, 1, 15'h4004, 1, 4'hF, 0, 0, "en", r);
    xfer(0, 1, 15'h4004, 0, 4'hF, 0, 0, "dis2", r);
    xfer(0, 0, 15'h4001, 0, 0, 1, 32'h1, "carry_hi", r);
    xfer(0, 0, 15'h4000, 0, 0, 0, 0, "rd_lo", r);
    check("carry_lo_small", r <= 3, 1);
    xfer(0, 1, 15'h4000, 0, 4'hF, 0, 0, "clr_lo", r);
    xfer(0, 1, 15'h4001, 0, 4'hF, 0, 0, "clr_hi", r);
    xfer(0, 1, 15'h4002, 20, 4'hF, 0, 0, "cmp_lo", r);
    xfer(0, 1, 15'h4003, 0, 4'hF, 0, 0, "cmp_hi", r);
    check("irq_off", irq[0], 0);
    xfer(0, 1, 15'h4004, 3, 4'hF, 0, 0, "irq_en", r);
    n = 0;
    while (!irq[0] && n < 100) begin @(negedge clk); n++; end
    check("irq_rise_time", n >= 18 && n <= 24, 1);
    repeat (3) @(negedge clk);
    check("irq_level", irq[0], 1);
    @(posedge clk); #1;
    xfer(0, 1, 15'h4002, 100, 4'hF, 0, 0, "cmp_up", r);
    repeat (2) @(negedge clk);
    check("irq_clear", irq[0], 0);
    @(posedge clk); #1;
    xfer(0, 1, 15'h4004, 0, 4'hF, 0, 0, "dis3", r);
    xfer(0, 1, 15'h4002, 32'hFFFF_FFFF, 4'hF, 0, 0, "cmp_ff", r);
    xfer(0, 1, 15'h4002, 32'hAABB_CCDD, 4'h2, 1, 32'hFFFF_FFFF, "wr_prewrite", r);
    xfer(0, 0, 15'h4002, 0, 0, 1, 32'hFFFF_CCFF, "lane_merge", r);
    xfer(0, 1, 15'h4002, 0, 4'h0, 0, 0, "bsel0", r);
    xfer(0, 0, 15'h4002, 0, 0, 1, 32'hFFFF_CCFF, "bsel0_noupd", r);
    xfer(0, 1, 15'h4006, 32'h1234_5678, 4'hF, 0, 0, "w_unmap", r);
    xfer(0, 0, 15'h4006, 0, 0, 1, 32'h0, "unmapped", r);
    xfer(0, 1, 15'h4004, 32'hFFFF_FFFC, 4'hF, 0, 0, "w_ctrl_hi", r);
    xfer(0, 0, 15'h4004, 0, 0, 1, 32'h0, "ctrl_rsvd", r);
    xfer(0, 1, 15'h4005, 32'h1234_5678, 4'h5, 0, 0, "w_pre_part", r);
    xfer(0, 0, 15'h4005, 0, 0, 1, 32'h0034_0078, "prescale_lanes", r);
    xfer(1, 0, 15'h4004, 0, 0, 1, 32'h0, "ws3_ctrl", r);
    ad[1] = 15'h0010; rd[1] = 1'b1; n = 0;
    repeat (20) begin @(negedge clk); if (rdy[1]) n++; end
    rd[1] = 1'b0;
    check("nohit_ready", n, 0);
    @(posedge clk); #1;
    xfer(1, 1, 15'h4005, 5, 4'hF, 0, 0, "ws3_wpre", r);
    xfer(1, 0, 15'h4005, 0, 0, 1, 32'h5, "ws3_pre", r);
    ad[1] = 15'h4004; wd[1] = 3; bs[1] = 4'hF; wr[1] = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1; wr[1] = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    n = 0;
    repeat (10) begin @(negedge clk); if (rdy[1]) n++; end
    check("abort_ready", n, 0);
    @(posedge clk); #1;
    xfer(1, 0, 15'h4005, 0, 0, 1, 32'h0, "abort_pre_rst", r);
    xfer(1, 0, 15'h4004, 0, 0, 1, 32'h0, "abort_ctrl", r);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
